// File: rtl/inpdt_pkg.sv
// Shared widths and arithmetic helpers for the pipelined inner-product accumulator.
package inpdt_pkg;

  localparam int unsigned DEF_LANES = 16;
  localparam int unsigned DEF_DW    = 9;
  localparam int unsigned DEF_ACC_W = 32;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

  localparam int unsigned PROD_W = 2 * DEF_DW;
  localparam int unsigned HALF_W = PROD_W + clog2(DEF_LANES) - 1;

  // Signed add clamped to a width-bit range; result is {overflow, sum}.
  function automatic logic [64:0] sat_add(input longint a, input longint b,
                                          input int unsigned width);
    longint s;
    longint mx;
    longint mn;
    s  = a + b;
    mx = (longint'(1) << (width - 1)) - 1;
    mn = -mx - 1;
    if (s > mx) return {1'b1, mx};
    if (s < mn) return {1'b1, mn};
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/inpdt_acc_pipe_if.sv
// Chunk input and result output bundle of the inner-product accumulator.
interface inpdt_acc_pipe_if
  import inpdt_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned ACC_W = DEF_ACC_W
);
  logic [LANES*DW-1:0]      iData_XH;
  logic [LANES*DW-1:0]      iData_W;
  logic                     iValid;
  logic                     iLast;
  logic                     iSplit;
  logic                     iClear;
  logic                     oReady;
  logic                     oValid;
  logic                     iOutReady;
  logic signed [ACC_W-1:0]  oResult;
  logic signed [ACC_W-1:0]  oResult_lo;
  logic signed [ACC_W-1:0]  oResult_hi;
  logic                     oSat;

  modport slave (
    input  iData_XH, iData_W, iValid, iLast, iSplit, iClear, iOutReady,
    output oReady, oValid, oResult, oResult_lo, oResult_hi, oSat
  );

  modport master (
    output iData_XH, iData_W, iValid, iLast, iSplit, iClear, iOutReady,
    input  oReady, oValid, oResult, oResult_lo, oResult_hi, oSat
  );
endinterface

// File: rtl/inpdt_tree_half.sv
// Signed adder tree over N products; every node is carried at the full output width.
module inpdt_tree_half
  import inpdt_pkg::*;
#(
  parameter int unsigned N     = DEF_LANES / 2,
  parameter int unsigned IN_W  = PROD_W,
  parameter int unsigned OUT_W = HALF_W
) (
  input  logic [N*IN_W-1:0]       prods,
  output logic signed [OUT_W-1:0] sum
);

  // Heap layout: leaves at [N-1 .. 2N-2], node i sums children 2i+1 and 2i+2.
  logic signed [OUT_W-1:0] node [2*N-1];

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      node[int'(N) - 1 + i] = OUT_W'($signed(prods[i*int'(IN_W) +: IN_W]));
    end
    for (int i = int'(N) - 2; i >= 0; i--) begin
      node[i] = node[2*i + 1] + node[2*i + 2];
    end
    sum = node[0];
  end

endmodule

// File: rtl/inpdt_acc_pipe.sv
// Pipelined LANES-wide inner product with per-half saturating accumulation across
// multi-chunk vectors: products, half-tree sums, accumulate, final add/output.
module inpdt_acc_pipe
  import inpdt_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic             iClk,
  input  logic             iRstn,
  inpdt_acc_pipe_if.slave  bus
);

  localparam int unsigned HL = LANES / 2;
  localparam int unsigned PW = 2 * DW;
  localparam int unsigned HW = PW + clog2(LANES) - 1;

  logic stall;
  logic accept;

  assign stall      = bus.oValid & ~bus.iOutReady;
  assign bus.oReady = ~stall;
  assign accept     = bus.iValid & ~stall & ~bus.iClear;

  // Lane products; lane 0 sits at the MSBs of the input bus.
  logic [LANES*PW-1:0] prod_c;
  for (genvar g = 0; g < int'(LANES); g++) begin : g_mul
    logic signed [DW-1:0] xe;
    logic signed [DW-1:0] we;
    assign xe = bus.iData_XH[(int'(LANES) - g)*int'(DW) - 1 -: DW];
    assign we = bus.iData_W [(int'(LANES) - g)*int'(DW) - 1 -: DW];
    assign prod_c[g*int'(PW) +: PW] = PW'(xe) * PW'(we);
  end

  logic [LANES*PW-1:0] prod_q;
  logic                v1;
  logic                last1;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      prod_q <= '0;
      v1     <= 1'b0;
      last1  <= 1'b0;
    end else if (bus.iClear) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
    end else if (!stall) begin
      v1    <= accept;
      last1 <= accept & bus.iLast;
      if (accept) prod_q <= prod_c;
    end
  end

  logic signed [HW-1:0] half_lo_c;
  logic signed [HW-1:0] half_hi_c;

  inpdt_tree_half #(.N(HL), .IN_W(PW), .OUT_W(HW)) u_tree_lo (
    .prods (prod_q[HL*PW-1:0]),
    .sum   (half_lo_c)
  );

  inpdt_tree_half #(.N(HL), .IN_W(PW), .OUT_W(HW)) u_tree_hi (
    .prods (prod_q[LANES*PW-1:HL*PW]),
    .sum   (half_hi_c)
  );

  logic signed [HW-1:0] half_lo;
  logic signed [HW-1:0] half_hi;
  logic                 v2;
  logic                 last2;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      half_lo <= '0;
      half_hi <= '0;
      v2      <= 1'b0;
      last2   <= 1'b0;
    end else if (bus.iClear) begin
      v2    <= 1'b0;
      last2 <= 1'b0;
    end else if (!stall) begin
      v2    <= v1;
      last2 <= last1;
      if (v1) begin
        half_lo <= half_lo_c;
        half_hi <= half_hi_c;
      end
    end
  end

  logic signed [ACC_W-1:0] acc_lo;
  logic signed [ACC_W-1:0] acc_hi;
  logic                    sticky;
  logic signed [ACC_W-1:0] sum_lo;
  logic signed [ACC_W-1:0] sum_hi;
  logic                    sat3;
  logic                    v3;

  logic [64:0]             r_lo;
  logic [64:0]             r_hi;
  logic [64:0]             r_fin;
  logic signed [ACC_W-1:0] next_lo;
  logic signed [ACC_W-1:0] next_hi;
  logic signed [ACC_W-1:0] fin;

  always_comb begin
    r_lo    = sat_add(64'(acc_lo), 64'(half_lo), ACC_W);
    r_hi    = sat_add(64'(acc_hi), 64'(half_hi), ACC_W);
    r_fin   = sat_add(64'(sum_lo), 64'(sum_hi), ACC_W);
    next_lo = ACC_W'(r_lo[63:0]);
    next_hi = ACC_W'(r_hi[63:0]);
    fin     = ACC_W'(r_fin[63:0]);
  end

  // Accumulate; a closing chunk hands its totals on and restarts the accumulators.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      acc_lo <= '0;
      acc_hi <= '0;
      sticky <= 1'b0;
      sum_lo <= '0;
      sum_hi <= '0;
      sat3   <= 1'b0;
      v3     <= 1'b0;
    end else if (bus.iClear) begin
      acc_lo <= '0;
      acc_hi <= '0;
      sticky <= 1'b0;
      v3     <= 1'b0;
    end else if (!stall) begin
      v3 <= v2 & last2;
      if (v2) begin
        if (last2) begin
          sum_lo <= next_lo;
          sum_hi <= next_hi;
          sat3   <= sticky | r_lo[64] | r_hi[64];
          acc_lo <= '0;
          acc_hi <= '0;
          sticky <= 1'b0;
        end else begin
          acc_lo <= next_lo;
          acc_hi <= next_hi;
          sticky <= sticky | r_lo[64] | r_hi[64];
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      bus.oValid     <= 1'b0;
      bus.oResult    <= '0;
      bus.oResult_lo <= '0;
      bus.oResult_hi <= '0;
      bus.oSat       <= 1'b0;
    end else if (bus.iClear) begin
      bus.oValid     <= 1'b0;
      bus.oResult    <= '0;
      bus.oResult_lo <= '0;
      bus.oResult_hi <= '0;
      bus.oSat       <= 1'b0;
    end else if (!stall) begin
      bus.oValid <= v3;
      if (v3) begin
        bus.oResult    <= fin;
        bus.oResult_lo <= sum_lo;
        bus.oResult_hi <= sum_hi;
        bus.oSat       <= sat3 | r_fin[64];
      end
    end
  end

endmodule
